// File: rtl/so3s_stream_sched.sv
// so3s_stream_sched: round-robin scheduler sharing one so3s_1D online
// sum-of-three-squares datapath between NUM_REQ digit-serial requesters.
module so3s_stream_sched #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         in_valid,
    input  logic [2*NUM_REQ-1:0]       in_x,
    input  logic [2*NUM_REQ-1:0]       in_y,
    input  logic [2*NUM_REQ-1:0]       in_z,
    output logic [NUM_REQ-1:0]         in_ready,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       busy,
    output logic                       dp_rst_n,
    output logic                       dp_en,
    output logic [1:0]                 dp_x,
    output logic [1:0]                 dp_y,
    output logic [1:0]                 dp_z,
    input  logic [3:0]                 dp_s,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [3:0]                 out_digit,
    output logic [$clog2(NUM_REQ)-1:0] out_id,
    output logic                       out_last,
    output logic                       abort
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CLEAR, RUN} state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      rr_ptr_q, rr_ptr_d, id_q, id_d, arb_idx;
    logic [NUM_REQ-1:0] gnt_q, gnt_d, arb_req;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               arb_hit, done;

    // At the end of an op the finishing requester is masked so others get a turn.
    always_comb begin
        arb_req = (state_q == RUN) ? req & ~gnt_q : req;
        arb_hit = 1'b0;
        arb_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (arb_req[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
                arb_hit = 1'b1;
                arb_idx = IW'((int'(rr_ptr_q) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        id_d      = id_q;
        in_ready  = '0;
        out_valid = 1'b0;
        abort     = 1'b0;
        case (state_q)
            CLEAR: begin
                abort   = ~req[id_q];
                state_d = abort ? IDLE : RUN;
                cnt_d   = '0;
            end
            RUN: begin
                abort          = ~req[id_q];
                out_valid      = in_valid[id_q] & ~abort;
                in_ready[id_q] = out_ready & ~abort;
                if (abort)
                    state_d = IDLE;
                else if (out_valid && out_ready)
                    cnt_d = (cnt_q == CW'(WIDTH - 1)) ? '0 : cnt_q + 1'b1;
            end
            default: ;
        endcase
        done = (state_q == RUN) && out_valid && out_ready && (cnt_q == CW'(WIDTH - 1));
        if (done)
            state_d = IDLE;
        if (state_d == IDLE)
            gnt_d = '0;
        if ((state_q == IDLE || done) && arb_hit) begin
            state_d  = CLEAR;
            gnt_d    = NUM_REQ'(1) << arb_idx;
            id_d     = arb_idx;
            rr_ptr_d = (arb_idx == IW'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            gnt_q    <= '0;
            id_q     <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            id_q     <= id_d;
        end
    end

    assign gnt       = gnt_q;
    assign busy      = state_q != IDLE;
    assign dp_rst_n  = state_q == RUN;
    assign dp_en     = out_valid & out_ready;
    assign dp_x      = dp_rst_n ? in_x[{id_q, 1'b0} +: 2] : 2'b00;
    assign dp_y      = dp_rst_n ? in_y[{id_q, 1'b0} +: 2] : 2'b00;
    assign dp_z      = dp_rst_n ? in_z[{id_q, 1'b0} +: 2] : 2'b00;
    assign out_digit = dp_s;
    assign out_id    = id_q;
    assign out_last  = out_valid && (cnt_q == CW'(WIDTH - 1));
endmodule
